// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtract/negate/pass/zero stage
module serial_subtractor #(
    parameter int INSTR_BITS   = 20,
    parameter int FLYBACK_TIME = 4
) (
    input  logic       w_DPG,
    input  logic       w_RESET_N,
    input  logic       w_A_DATA_OUT,
    input  logic       w_MS_DATA_OUT,
    input  logic [1:0] b_OP,
    output logic       w_RESULT,
    output logic       w_NEG,
    output logic       w_OVF,
    output logic       w_WORD_DONE
);

    localparam int WORD_BEATS = INSTR_BITS + FLYBACK_TIME;
    localparam int CW         = $clog2(WORD_BEATS) + 1;

    localparam logic [CW-1:0] LAST_BEAT  = CW'(WORD_BEATS - 1);
    localparam logic [CW-1:0] MSB_BEAT   = CW'(INSTR_BITS - 1);
    localparam logic [CW-1:0] DATA_BEATS = CW'(INSTR_BITS);

    localparam logic [1:0] OP_NEG  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_ZERO = 2'b11;

    logic [CW-1:0] beat;
    logic [1:0]    op_q;
    logic          carry_q;

    logic       first_beat;
    logic       data_beat;
    logic [1:0] op_eff;
    logic       a_bit;
    logic       s_bit;
    logic       c_in;
    logic       sum_bit;
    logic       c_out;

    // Operand selection and one full-adder slice; beat 0 uses b_OP directly
    // because the op latch only captures it on that same edge.
    always_comb begin
        first_beat = (beat == '0);
        data_beat  = (beat < DATA_BEATS);
        op_eff     = first_beat ? b_OP : op_q;
        a_bit      = ((op_eff == OP_SUB) || (op_eff == OP_PASS)) ? w_A_DATA_OUT : 1'b0;
        s_bit      = ((op_eff == OP_SUB) || (op_eff == OP_NEG)) ? ~w_MS_DATA_OUT : 1'b0;
        c_in       = first_beat ? ((op_eff == OP_SUB) || (op_eff == OP_NEG)) : carry_q;
        sum_bit    = a_bit ^ s_bit ^ c_in;
        c_out      = (a_bit & s_bit) | (a_bit & c_in) | (s_bit & c_in);
    end

    // Free-running beat counter covering data and flyback beats.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            beat <= '0;
        end else if (beat == LAST_BEAT) begin
            beat <= '0;
        end else begin
            beat <= beat + 1'b1;
        end
    end

    // Operation is captured at beat 0 and held for the rest of the word.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            op_q <= OP_ZERO;
        end else if (first_beat) begin
            op_q <= b_OP;
        end
    end

    // Ripple carry between data beats; cleared in flyback so nothing leaks across words.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            carry_q <= 1'b0;
        end else if (data_beat) begin
            carry_q <= c_out;
        end else begin
            carry_q <= 1'b0;
        end
    end

    // Registered serial result: bit k appears in beat k+1, zero otherwise.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            w_RESULT <= 1'b0;
        end else if (data_beat) begin
            w_RESULT <= sum_bit;
        end else begin
            w_RESULT <= 1'b0;
        end
    end

    // Sign and overflow captured from the MSB slice, held until the next word ends.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            w_NEG <= 1'b0;
            w_OVF <= 1'b0;
        end else if (beat == MSB_BEAT) begin
            w_NEG <= sum_bit;
            w_OVF <= c_in ^ c_out;
        end
    end

    // One-beat completion pulse aligned with the MSB on w_RESULT.
    always_ff @(posedge w_DPG or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            w_WORD_DONE <= 1'b0;
        end else begin
            w_WORD_DONE <= (beat == MSB_BEAT);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int IB = 20;
    localparam int FB = 4;
    localparam int WB = IB + FB;
    localparam int NO_BEAT = 1000;

    logic       w_DPG;
    logic       w_RESET_N;
    logic       w_A_DATA_OUT;
    logic       w_MS_DATA_OUT;
    logic [1:0] b_OP;
    logic       w_RESULT;
    logic       w_NEG;
    logic       w_OVF;
    logic       w_WORD_DONE;

    int tests;
    int fails;
    logic prev_neg;
    logic prev_ovf;

    serial_subtractor #(.INSTR_BITS(IB), .FLYBACK_TIME(FB)) dut (
        .w_DPG         (w_DPG),
        .w_RESET_N     (w_RESET_N),
        .w_A_DATA_OUT  (w_A_DATA_OUT),
        .w_MS_DATA_OUT (w_MS_DATA_OUT),
        .b_OP          (b_OP),
        .w_RESULT      (w_RESULT),
        .w_NEG         (w_NEG),
        .w_OVF         (w_OVF),
        .w_WORD_DONE   (w_WORD_DONE)
    );

    initial w_DPG = 1'b0;
    always #5 w_DPG = ~w_DPG;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input logic [IB-1:0] v);
        int r;
        r = int'(v);
        if (v[IB-1]) r = r - (1 << IB);
        return r;
    endfunction

    function automatic logic [IB-1:0] model_res(input logic [1:0] op, input logic [IB-1:0] a,
                                                input logic [IB-1:0] s);
        logic [IB-1:0] zero;
        zero = '0;
        case (op)
            2'b00:   return zero - s;
            2'b01:   return a - s;
            2'b10:   return a;
            default: return zero;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [1:0] op, input logic [IB-1:0] a,
                                       input logic [IB-1:0] s);
        int d;
        case (op)
            2'b00:   d = 0 - to_signed(s);
            2'b01:   d = to_signed(a) - to_signed(s);
            default: d = 0;
        endcase
        return (d > (1 << (IB - 1)) - 1) || (d < -(1 << (IB - 1)));
    endfunction

    // Runs one word starting just before its beat-0 edge. b_OP switches to mid_op
    // from mid_beat onward; abort_beat asserts reset in that beat and ends the word.
    task automatic run_word(input string name, input logic [1:0] op, input logic [IB-1:0] a,
                            input logic [IB-1:0] s, input logic [1:0] mid_op,
                            input int mid_beat, input int abort_beat);
        logic [IB-1:0] res;
        logic [IB-1:0] exp_res;
        res = '0;
        for (int k = 0; k < WB; k++) begin
            @(negedge w_DPG);
            w_A_DATA_OUT  = (k < IB) ? a[k] : (($urandom & 1) == 1);
            w_MS_DATA_OUT = (k < IB) ? s[k] : (($urandom & 1) == 1);
            b_OP          = (k > 0 && k >= mid_beat) ? mid_op : op;
            if (k == abort_beat) begin
                w_RESET_N = 1'b0;
                #1;
                check({name, "_rst_result"}, 32'(w_RESULT), 32'd0);
                check({name, "_rst_neg"}, 32'(w_NEG), 32'd0);
                check({name, "_rst_ovf"}, 32'(w_OVF), 32'd0);
                check({name, "_rst_done"}, 32'(w_WORD_DONE), 32'd0);
                prev_neg = 1'b0;
                prev_ovf = 1'b0;
                @(posedge w_DPG);
                #1;
                w_RESET_N = 1'b1;
                return;
            end
            @(posedge w_DPG);
            #1;
            if (k < IB) res[k] = w_RESULT;
            else check({name, "_flyback"}, 32'(w_RESULT), 32'd0);
            check({name, "_done"}, 32'(w_WORD_DONE), (k == IB - 1) ? 32'd1 : 32'd0);
            if (k < IB - 1) begin
                check({name, "_hold_neg"}, 32'(w_NEG), 32'(prev_neg));
                check({name, "_hold_ovf"}, 32'(w_OVF), 32'(prev_ovf));
            end
        end
        exp_res = model_res(op, a, s);
        check({name, "_result"}, 32'(res), 32'(exp_res));
        check({name, "_neg"}, 32'(w_NEG), 32'(exp_res[IB-1]));
        check({name, "_ovf"}, 32'(w_OVF), 32'(model_ovf(op, a, s)));
        prev_neg = exp_res[IB-1];
        prev_ovf = model_ovf(op, a, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests         = 0;
        fails         = 0;
        prev_neg      = 1'b0;
        prev_ovf      = 1'b0;
        w_RESET_N     = 1'b0;
        w_A_DATA_OUT  = 1'b0;
        w_MS_DATA_OUT = 1'b0;
        b_OP          = 2'b11;
        repeat (2) @(posedge w_DPG);
        #1;
        check("reset_result", 32'(w_RESULT), 32'd0);
        check("reset_neg", 32'(w_NEG), 32'd0);
        check("reset_ovf", 32'(w_OVF), 32'd0);
        check("reset_done", 32'(w_WORD_DONE), 32'd0);
        w_RESET_N = 1'b1;

        run_word("sub_5_3", 2'b01, 20'd5, 20'd3, 2'b01, NO_BEAT, NO_BEAT);
        run_word("neg_1", 2'b00, 20'h12345, 20'd1, 2'b00, NO_BEAT, NO_BEAT);
        run_word("neg_0", 2'b00, 20'hFFFFF, 20'd0, 2'b00, NO_BEAT, NO_BEAT);
        run_word("sub_ovf", 2'b01, 20'h7FFFF, 20'hFFFFF, 2'b01, NO_BEAT, NO_BEAT);
        run_word("pass_abcde", 2'b10, 20'hABCDE, 20'h55555, 2'b11, 7, NO_BEAT);
        run_word("zero", 2'b11, 20'hFFFFF, 20'h00001, 2'b11, NO_BEAT, NO_BEAT);
        run_word("neg_min", 2'b00, 20'h0, 20'h80000, 2'b00, NO_BEAT, NO_BEAT);
        run_word("pre_abort", 2'b01, 20'h7FFFF, 20'hFFFFF, 2'b01, NO_BEAT, NO_BEAT);
        run_word("abort", 2'b01, 20'h00123, 20'h00456, 2'b01, NO_BEAT, 10);
        run_word("sub_9_4", 2'b01, 20'd9, 20'd4, 2'b01, NO_BEAT, NO_BEAT);

        for (int w = 0; w < 16; w++) begin
            logic [1:0]    r_op;
            logic [1:0]    r_mid;
            logic [IB-1:0] r_a;
            logic [IB-1:0] r_s;
            r_op  = 2'($urandom_range(3, 0));
            r_mid = 2'($urandom_range(3, 0));
            r_a   = IB'($urandom);
            r_s   = IB'($urandom);
            run_word("random", r_op, r_a, r_s, r_mid, $urandom_range(WB - 1, 1), NO_BEAT);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial arithmetic stage between the accumulator read unit / main store outputs and the accumulator write unit.
- Each word time it combines the accumulator stream and the store stream LSB-first, producing the serial result that is written back to the accumulator.
- Also produces the end-of-word sign and overflow flags used by the control unit for the skip-if-negative test.
- Word timing is INSTR_BITS data beats followed by FLYBACK_TIME idle beats, one beat per w_DPG rising edge.

Parameters:
- INSTR_BITS, 20, bits per word; the stream is LSB-first and two's complement.
- FLYBACK_TIME, 4, idle beats after the data beats of each word.

Ports:
- w_DPG  input  1  digit pulse clock; all state updates on the rising edge.
- w_RESET_N  input  1  asynchronous, active-low reset.
- w_A_DATA_OUT  input  1  accumulator serial bit; bit k is valid in beat k.
- w_MS_DATA_OUT  input  1  store serial bit; bit k is valid in beat k.
- b_OP  input  2  operation: 00 = NEG (0 - S), 01 = SUB (A - S), 10 = PASS (A), 11 = ZERO (result 0).
- w_RESULT  output  1  serial result bit to the accumulator write unit.
- w_NEG  output  1  sign of the last completed result.
- w_OVF  output  1  signed overflow of the last completed result.
- w_WORD_DONE  output  1  one-beat pulse when a word result completes.

Behaviour:
- Beat counter:
  - Free-running, 0 .. INSTR_BITS+FLYBACK_TIME-1, advancing on every w_DPG edge.
  - Wraps to 0 after the last flyback beat.
  - Counter width is $clog2(INSTR_BITS+FLYBACK_TIME)+1.
- Op latch: b_OP is sampled on the edge where counter==0 and held for the whole word. Changes to b_OP mid-word have no effect until the next beat 0.
- Operand mapping for each data beat k (counter < INSTR_BITS):
  - a = w_A_DATA_OUT for SUB and PASS, 0 for NEG and ZERO.
  - s = ~w_MS_DATA_OUT for SUB and NEG, 0 for PASS and ZERO.
  - Carry-in at beat 0 is 1 for SUB and NEG, 0 for PASS and ZERO. This gives A + ~S + 1, i.e. two's-complement subtraction.
  - Sum bit = a ^ s ^ c. Carry updates to the majority of (a, s, c).
  - The carry register is forced to its per-op initial value at beat 0 and never leaks between words.
- Result output:
  - Registered; w_RESULT carries bit k during beat k+1, so latency is 1 beat.
  - w_RESULT = 0 throughout flyback, except for the bit INSTR_BITS-1 output, which appears in the first flyback beat.
- Flags, updated on the edge where counter==INSTR_BITS-1:
  - w_NEG <= sum bit INSTR_BITS-1.
  - w_OVF <= carry-in to the MSB XOR carry-out of the MSB.
  - Both hold their value until the next word completes.
  - For PASS and ZERO, w_OVF is always 0.
- w_WORD_DONE is high for exactly one beat, the beat after counter==INSTR_BITS-1, which coincides with the MSB appearing on w_RESULT.
- Reset:
  - On asynchronous assertion: counter=0, carry=0, latched op=ZERO, and w_RESULT, w_NEG, w_OVF, w_WORD_DONE all 0.
  - Reset asserted mid-word aborts that word and its flags are not updated.
  - After deassertion, the first rising edge is treated as beat 0 of a new word.
- Arithmetic is modulo 2^INSTR_BITS; there is no saturation.

Test Plan:
- SUB, A=5, S=3: w_RESULT stream reads 0x00002 (LSB first, beats 1..20); w_NEG=0, w_OVF=0; w_WORD_DONE pulses once in beat 20.
- NEG, S=1: result 0xFFFFF, w_NEG=1, w_OVF=0.
- NEG, S=0: result 0x00000; checks that the carry-out is discarded.
- SUB, A=0x7FFFF, S=0xFFFFF (-1): result 0x80000, w_NEG=1, w_OVF=1.
- Back-to-back words:
  - PASS with A=0xABCDE, then ZERO.
  - First result is 0xABCDE; second is 0x00000 with w_NEG=0.
  - b_OP changed at beat 7 of the first word: no effect on that word.
  - Flyback beats output 0.
- Reset pulsed low during beat 10 of a SUB:
  - All outputs go to 0 immediately.
  - Flags from the previous word are cleared.
  - After release, the next full word computes correctly: A=9, S=4 gives 5.
